// File: rtl/parallel_serial_if.sv
// DAC serializer bus: frame clock, sample load strobe,
// serial output and status pulses.
interface parallel_serial_if #(
  parameter int DATA_W = 32
);
  logic              i_lrclk;
  logic [DATA_W-1:0] i_data_parallel_DAC;
  logic              i_load_DAC;
  logic              o_data_serial_DAC;
  logic              o_busy;
  logic              o_frame_done;
  logic              o_underrun;
  logic              o_overrun;

  modport master (
    output i_lrclk,
    output i_data_parallel_DAC,
    output i_load_DAC,
    input  o_data_serial_DAC,
    input  o_busy,
    input  o_frame_done,
    input  o_underrun,
    input  o_overrun
  );

  modport slave (
    input  i_lrclk,
    input  i_data_parallel_DAC,
    input  i_load_DAC,
    output o_data_serial_DAC,
    output o_busy,
    output o_frame_done,
    output o_underrun,
    output o_overrun
  );
endinterface

// File: rtl/parallel_serial.sv
// DAC serializer: one held sample per frame, shifted
// out MSB-first after each rising edge of the frame clock.
module parallel_serial #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input logic               i_clk,
  input logic               i_rst_n,
  parallel_serial_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] hold_q;
  logic              hold_valid;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  count_q;
  logic              lrclk_q;
  logic              frame_done_q;
  logic              underrun_q;
  logic              overrun_q;

  logic lr_rise;
  logic start;
  logic consume;
  logic bypass;
  logic load;

  assign load    = bus.i_load_DAC;
  assign lr_rise = bus.i_lrclk & ~lrclk_q;
  assign start   = (state == IDLE) & lr_rise;
  assign consume = start & hold_valid;
  // Empty hold plus a same-cycle load feeds the shifter directly
  assign bypass  = start & ~hold_valid & load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      hold_q       <= '0;
      hold_valid   <= 1'b0;
      shift_q      <= '0;
      count_q      <= '0;
      lrclk_q      <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      lrclk_q      <= bus.i_lrclk;
      frame_done_q <= 1'b0;
      underrun_q   <= start & ~hold_valid & ~load;
      overrun_q    <= load & hold_valid & ~consume;

      if (load && !bypass) begin
        hold_q     <= bus.i_data_parallel_DAC;
        hold_valid <= 1'b1;
      end else if (consume) begin
        hold_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= SHIFT;
            count_q <= CNT_W'(DATA_W - 1);
            if (hold_valid)
              shift_q <= hold_q;
            else if (load)
              shift_q <= bus.i_data_parallel_DAC;
            else
              shift_q <= '0;
          end
        end
        SHIFT: begin
          shift_q <= {shift_q[DATA_W-2:0], 1'b0};
          if (count_q == '0) begin
            state        <= DONE;
            frame_done_q <= 1'b1;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          shift_q <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign bus.o_data_serial_DAC = (state == SHIFT)
                               & shift_q[DATA_W-1];
  assign bus.o_busy       = (state == SHIFT) | (state == DONE);
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_underrun   = underrun_q;
  assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_parallel_serial.sv
// Scoreboard bench for parallel_serial: stimulus pushes
// expected frames, a negedge monitor pops and compares.
module tb_parallel_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [31:0] word;
    int          ur;
    int          done_cyc;
  } exp_t;

  exp_t q[$];
  int   pushed = 0;
  int   frames_seen = 0;
  int   ur_total = 0;
  int   ov_total = 0;

  parallel_serial_if #(.DATA_W(32)) bus ();

  parallel_serial #(.DATA_W(32), .CNT_W(5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [31:0] d);
    bus.i_data_parallel_DAC = d;
    bus.i_load_DAC = 1'b1;
    tick();
    bus.i_load_DAC = 1'b0;
  endtask

  task automatic expect_frame(input logic [31:0] w, input int ur);
    exp_t e;
    e.word = w;
    e.ur = ur;
    e.done_cyc = cyc + 33;
    q.push_back(e);
    pushed++;
  endtask

  // rise now, keep high a while, then low; 40 cycles total
  task automatic frame_tail;
    tick();
    tick(15);
    bus.i_lrclk = 1'b0;
    tick(24);
  endtask

  task automatic run_frame(input logic [31:0] w, input int ur);
    bus.i_lrclk = 1'b1;
    expect_frame(w, ur);
    frame_tail();
  endtask

  // Monitor
  logic [31:0] acc;
  int          nbits = 0;
  int          ur_in = 0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0;
      ur_in = 0;
      acc = '0;
    end else begin
      if (bus.o_underrun) begin
        ur_total++;
        ur_in++;
      end
      if (bus.o_overrun) ov_total++;
      if (!bus.o_busy)
        check("idle_serial", {31'd0, bus.o_data_serial_DAC}, 32'd0);
      if (bus.o_busy && !bus.o_frame_done) begin
        acc = {acc[30:0], bus.o_data_serial_DAC};
        nbits++;
      end
      if (bus.o_frame_done) begin
        frames_seen++;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got %h expected none", acc);
        end else begin
          e = q.pop_front();
          check("frame_word", acc, e.word);
          check("frame_bits", nbits, 32);
          check("frame_underrun", ur_in, e.ur);
          check("frame_done_cycle", cyc, e.done_cyc);
        end
        nbits = 0;
        ur_in = 0;
        acc = '0;
      end
    end
  end

  initial begin
    bus.i_lrclk = 1'b0;
    bus.i_load_DAC = 1'b0;
    bus.i_data_parallel_DAC = '0;
    tick(3);
    check("rst_serial", {31'd0, bus.o_data_serial_DAC}, 32'd0);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_flags", {29'd0, bus.o_frame_done,
          bus.o_underrun, bus.o_overrun}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", {31'd0, bus.o_busy}, 32'd0);
    tick(4);

    // basic frame
    load(32'hA5A5_0F0F);
    tick(2);
    run_frame(32'hA5A5_0F0F, 0);

    // underrun: hold was consumed by previous frame
    run_frame(32'h0000_0000, 1);
    check("ur_total_1", ur_total, 1);

    // overrun: newest sample wins
    load(32'h1111_1111);
    load(32'h8000_0001);
    tick(2);
    run_frame(32'h8000_0001, 0);
    check("ov_total_1", ov_total, 1);

    // load in the rise cycle refills hold
    load(32'hDEAD_BEEF);
    tick(2);
    bus.i_lrclk = 1'b1;
    bus.i_data_parallel_DAC = 32'hCAFE_F00D;
    bus.i_load_DAC = 1'b1;
    expect_frame(32'hDEAD_BEEF, 0);
    tick();
    bus.i_load_DAC = 1'b0;
    tick(15);
    bus.i_lrclk = 1'b0;
    tick(24);
    run_frame(32'hCAFE_F00D, 0);
    check("ov_total_2", ov_total, 1);

    // bypass: empty hold, load in the rise cycle
    bus.i_lrclk = 1'b1;
    bus.i_data_parallel_DAC = 32'h3C96_5AA5;
    bus.i_load_DAC = 1'b1;
    expect_frame(32'h3C96_5AA5, 0);
    tick();
    bus.i_load_DAC = 1'b0;
    tick(15);
    bus.i_lrclk = 1'b0;
    tick(24);
    // hold must still be empty after bypass
    run_frame(32'h0000_0000, 1);
    check("ur_total_2", ur_total, 2);

    // second rise during SHIFT is ignored
    load(32'h1234_5678);
    tick(2);
    bus.i_lrclk = 1'b1;
    expect_frame(32'h1234_5678, 0);
    tick(10);
    bus.i_lrclk = 1'b0;
    tick();
    bus.i_lrclk = 1'b1;
    tick();
    bus.i_lrclk = 1'b0;
    tick(28);
    check("toggle_idle", {31'd0, bus.o_busy}, 32'd0);
    check("ur_total_3", ur_total, 2);

    // reset at bit 16 of an all-ones frame
    load(32'hFFFF_FFFF);
    tick(2);
    bus.i_lrclk = 1'b1;
    tick(17);
    check("bit16_before_rst", {31'd0, bus.o_data_serial_DAC}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_serial", {31'd0, bus.o_data_serial_DAC}, 32'd0);
    check("rst_async_busy", {31'd0, bus.o_busy}, 32'd0);
    bus.i_lrclk = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    run_frame(32'h0000_0000, 1);
    check("ur_total_4", ur_total, 3);

    for (int i = 0; i < 100 && q.size() != 0; i++) tick();
    check("queue_empty", q.size(), 0);
    check("frames_seen", frames_seen, pushed);
    check("ov_total_end", ov_total, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
